// File: rtl/controlador_despacho.sv
// Dispense controller downstream of the coin adder: prices a button press against
// the balance, pulses accept, then sequences cup motor, coffee, optional milk and ready.
module controlador_despacho #(
   parameter int unsigned PRECIO_NEGRO = 5,
   parameter int unsigned PRECIO_LECHE = 7,
   parameter int unsigned T_VASO       = 50_000_000,
   parameter int unsigned T_CAFE       = 150_000_000,
   parameter int unsigned T_LECHE      = 100_000_000,
   parameter int unsigned T_LISTO      = 100_000_000,
   parameter int unsigned CW           = 28
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] saldo,
   input  logic [1:0] seleccion,
   output logic       aceptada,
   output logic [3:0] vuelto,
   output logic       falta,
   output logic       motor_vaso,
   output logic       valv_cafe,
   output logic       valv_leche,
   output logic       listo,
   output logic       ocupado
);

   localparam logic [2:0] ESPERA = 3'd0;
   localparam logic [2:0] COBRO  = 3'd1;
   localparam logic [2:0] VASO   = 3'd2;
   localparam logic [2:0] CAFE   = 3'd3;
   localparam logic [2:0] LECHE  = 3'd4;
   localparam logic [2:0] LISTO  = 3'd5;

   localparam logic [CW-1:0] CARGA_VASO  = CW'(T_VASO - 1);
   localparam logic [CW-1:0] CARGA_CAFE  = CW'(T_CAFE - 1);
   localparam logic [CW-1:0] CARGA_LECHE = CW'(T_LECHE - 1);
   localparam logic [CW-1:0] CARGA_LISTO = CW'(T_LISTO - 1);
   localparam logic [3:0]    P_NEGRO     = 4'(PRECIO_NEGRO);
   localparam logic [3:0]    P_LECHE     = 4'(PRECIO_LECHE);

   logic [2:0]    state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          con_leche, con_leche_n;
   logic [3:0]    vuelto_n;
   logic          falta_n;
   logic [1:0]    sel_prev;
   logic [1:0]    pulso;
   logic [3:0]    precio;
   logic          fin;

   assign pulso  = seleccion & ~sel_prev;
   assign precio = pulso[1] ? P_LECHE : P_NEGRO;
   assign fin    = (cnt == '0);

   // Next-state, timer and latched-purchase logic
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      con_leche_n = con_leche;
      vuelto_n    = vuelto;
      falta_n     = 1'b0;
      case (state)
         ESPERA: begin
            if (pulso == 2'b01 || pulso == 2'b10) begin
               if (saldo >= precio) begin
                  state_n     = COBRO;
                  con_leche_n = pulso[1];
                  vuelto_n    = saldo - precio;
               end else begin
                  falta_n = 1'b1;
               end
            end
         end
         COBRO: begin
            state_n = VASO;
            cnt_n   = CARGA_VASO;
         end
         VASO: begin
            if (fin) begin
               state_n = CAFE;
               cnt_n   = CARGA_CAFE;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         CAFE: begin
            if (fin) begin
               if (con_leche) begin
                  state_n = LECHE;
                  cnt_n   = CARGA_LECHE;
               end else begin
                  state_n = LISTO;
                  cnt_n   = CARGA_LISTO;
               end
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         LECHE: begin
            if (fin) begin
               state_n = LISTO;
               cnt_n   = CARGA_LISTO;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         LISTO: begin
            if (fin) begin
               state_n  = ESPERA;
               vuelto_n = 4'd0;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         default: begin
            state_n = ESPERA;
            cnt_n   = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with the state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ESPERA;
         cnt        <= '0;
         con_leche  <= 1'b0;
         vuelto     <= 4'd0;
         sel_prev   <= 2'b11;
         falta      <= 1'b0;
         aceptada   <= 1'b0;
         motor_vaso <= 1'b0;
         valv_cafe  <= 1'b0;
         valv_leche <= 1'b0;
         listo      <= 1'b0;
         ocupado    <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         con_leche  <= con_leche_n;
         vuelto     <= vuelto_n;
         sel_prev   <= seleccion;
         falta      <= falta_n;
         aceptada   <= (state_n == COBRO);
         motor_vaso <= (state_n == VASO);
         valv_cafe  <= (state_n == CAFE);
         valv_leche <= (state_n == LECHE);
         listo      <= (state_n == LISTO);
         ocupado    <= (state_n != ESPERA);
      end
   end

endmodule
